// File: rtl/vga_anim_pkg.sv
// Shared definitions for the VGA animation blocks.
//   - Default 640x480 active resolution and the 800x525 totals.
//   - rgb_t: 12-bit 4:4:4 colour, plus the named colour constants.
//   - axis_t / axis_step: one axis of bouncing-box motion (position + direction).
package vga_anim_pkg;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_TOTAL   = 525;

    typedef logic [11:0] rgb_t;

    localparam rgb_t COLOR_BLACK = 12'h000;
    localparam rgb_t COLOR_RED   = 12'hF00;
    localparam rgb_t COLOR_BLUE  = 12'h00F;

    // dir: 1 = increasing coordinate (right/down), 0 = decreasing.
    typedef struct packed {
        logic       dir;
        logic [9:0] pos;
    } axis_t;

    // One frame of motion on one axis. Arithmetic is 11 bits wide so the
    // sum near the far edge cannot wrap; limit is the largest legal position.
    function automatic axis_t axis_step(input axis_t      cur,
                                        input logic [10:0] limit,
                                        input logic [10:0] step);
        axis_t       nxt;
        logic [10:0] pos_w;
        logic [10:0] sum;
        nxt   = cur;
        pos_w = {1'b0, cur.pos};
        sum   = '0;
        if (cur.dir) begin
            sum = pos_w + step;
            if (sum >= limit) begin
                nxt.pos = limit[9:0];
                nxt.dir = 1'b0;
            end else begin
                nxt.pos = sum[9:0];
            end
        end else begin
            if (pos_w <= step) begin
                nxt.pos = '0;
                nxt.dir = 1'b1;
            end else begin
                sum     = pos_w - step;
                nxt.pos = sum[9:0];
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/box_motion.sv
// Position/direction registers of the bouncing square.
//   clk, rst     : clock, synchronous active-high reset
//   step_en      : advance one frame of motion this cycle
//   box_x, box_y : top-left corner of the square (10 bits each)
module box_motion
    import vga_anim_pkg::*;
#(
    parameter int unsigned H_RES    = H_RES_DEF,
    parameter int unsigned V_RES    = V_RES_DEF,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_en,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    localparam logic [10:0] X_LIM  = 11'(H_RES - BOX_SIZE);
    localparam logic [10:0] Y_LIM  = 11'(V_RES - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);

    axis_t x_q, x_d;
    axis_t y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (step_en) begin
            x_d = axis_step(x_q, X_LIM, STEP_W);
            y_d = axis_step(y_q, Y_LIM, STEP_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q.pos <= '0;
            x_q.dir <= 1'b1;
            y_q.pos <= '0;
            y_q.dir <= 1'b1;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign box_x = x_q.pos;
    assign box_y = y_q.pos;

endmodule

// File: rtl/vga_box_render.sv
// Pixel stage behind the 640x480 VGA sync generator: draws a bouncing square.
//   clk, rst            : 100 MHz clock, synchronous active-high reset
//   p_tick              : pixel enable (one clk in four)
//   video_on            : active-area flag
//   hsync_in, vsync_in  : syncs from the generator
//   pixel_x, pixel_y    : current coordinate
//   pause               : hold motion (only when VGA_BOX_PAUSE_EN is defined)
//   hsync_out, vsync_out: syncs delayed 2 pixel ticks, aligned with rgb
//   rgb                 : 12-bit colour, 2 pixel ticks behind the coordinate
//   frame_tick          : one-clk pulse when the position updates
// Build option: VGA_BOX_PAUSE_EN adds the pause port.
module vga_box_render
    import vga_anim_pkg::*;
#(
    parameter int unsigned H_RES     = H_RES_DEF,
    parameter int unsigned V_RES     = V_RES_DEF,
    parameter int unsigned BOX_SIZE  = 32,
    parameter int unsigned STEP      = 2,
    parameter rgb_t        BOX_COLOR = COLOR_RED,
    parameter rgb_t        BG_COLOR  = COLOR_BLUE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
`ifdef VGA_BOX_PAUSE_EN
    input  logic       pause,
`endif
    output logic       hsync_out,
    output logic       vsync_out,
    output rgb_t       rgb,
    output logic       frame_tick
);

    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
    localparam logic [9:0]  V_BLANK0 = 10'(V_RES);

    logic [9:0] box_x, box_y;
    logic       frame_ev;
    logic       step_en;
    logic       hit;

    logic       hit_s1_q, von_s1_q, hs_s1_q, vs_s1_q;
    rgb_t       rgb_q, rgb_d;
    logic       hs_q, vs_q, frame_q;

    // First pixel of the first blank line: motion never lands mid-picture.
    assign frame_ev = p_tick && (pixel_x == 10'd0) && (pixel_y == V_BLANK0);

`ifdef VGA_BOX_PAUSE_EN
    assign step_en = frame_ev && !pause;
`else
    assign step_en = frame_ev;
`endif

    box_motion #(
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_motion (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .box_x   (box_x),
        .box_y   (box_y)
    );

    always_comb begin
        hit = ({1'b0, pixel_x} >= {1'b0, box_x}) &&
              ({1'b0, pixel_x} <  ({1'b0, box_x} + BOX_W)) &&
              ({1'b0, pixel_y} >= {1'b0, box_y}) &&
              ({1'b0, pixel_y} <  ({1'b0, box_y} + BOX_W));
    end

    always_comb begin
        rgb_d = COLOR_BLACK;
        if (von_s1_q)
            rgb_d = hit_s1_q ? BOX_COLOR : BG_COLOR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_s1_q <= 1'b0;
            von_s1_q <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            rgb_q    <= COLOR_BLACK;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            frame_q <= frame_ev;
            if (p_tick) begin
                hit_s1_q <= hit;
                von_s1_q <= video_on;
                hs_s1_q  <= hsync_in;
                vs_s1_q  <= vsync_in;
                rgb_q    <= rgb_d;
                hs_q     <= hs_s1_q;
                vs_q     <= vs_s1_q;
            end
        end
    end

    assign rgb        = rgb_q;
    assign hsync_out  = hs_q;
    assign vsync_out  = vs_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_vga_box_render.sv
module tb_vga_box_render;
    import vga_anim_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_tick = 1'b0;
    logic       video_on = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
`ifdef VGA_BOX_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       hsync_out, vsync_out, frame_tick;
    rgb_t       rgb;

    int tests  = 0;
    int failed = 0;
    int ft_cnt = 0;

    vga_box_render dut (
        .clk        (clk),
        .rst        (rst),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
`ifdef VGA_BOX_PAUSE_EN
        .pause      (pause),
`endif
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_tick) ft_cnt++;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y,
                         input logic von, input logic hs, input logic vs);
        pixel_x  = x;
        pixel_y  = y;
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    // One pixel period: p_tick for one clk, then three idle clks.
    task automatic tick();
        @(negedge clk) p_tick = 1'b1;
        @(negedge clk) p_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_event();
        @(negedge clk) drive(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic check_pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                               input logic [11:0] exp);
        @(negedge clk) drive(x, y, 1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk) drive(10'd700, 10'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk(name, 32'(rgb), 32'(exp));
    endtask

    int ft_before;

    initial begin
        vecs[0] = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 12'hF00};
        vecs[1] = '{10'd32,  10'd0,   1'b1, 1'b1, 1'b1, 12'h00F};
        vecs[2] = '{10'd31,  10'd31,  1'b1, 1'b0, 1'b1, 12'hF00};
        vecs[3] = '{10'd31,  10'd32,  1'b1, 1'b0, 1'b1, 12'h00F};
        vecs[4] = '{10'd700, 10'd0,   1'b0, 1'b1, 1'b0, 12'h000};
        vecs[5] = '{10'd10,  10'd10,  1'b0, 1'b0, 1'b0, 12'h000};
        vecs[6] = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b0, 12'h00F};
        vecs[7] = '{10'd0,   10'd31,  1'b1, 1'b0, 1'b1, 12'hF00};
        vecs[8] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 12'h000};

        // Reset with busy inputs; nothing may leak to the outputs.
        drive(10'd5, 10'd5, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk) p_tick = 1'b1;
        @(negedge clk) begin rst = 1'b0; p_tick = 1'b0; end
        chk("reset_rgb",   32'(rgb), 32'h0);
        chk("reset_hs",    32'(hsync_out), 32'h0);
        chk("reset_vs",    32'(vsync_out), 32'h0);
        chk("reset_ft",    32'(frame_tick), 32'h0);
        chk("reset_box_x", 32'(dut.u_motion.box_x), 32'd0);
        chk("reset_box_y", 32'(dut.u_motion.box_y), 32'd0);

        // Table: after tick i, outputs show vector i-1 (two-tick latency).
        for (int i = 0; i < 9; i++) begin
            @(negedge clk) drive(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].hs, vecs[i].vs);
            tick();
            if (i >= 1) begin
                chk($sformatf("vec%0d_rgb", i - 1), 32'(rgb), 32'(vecs[i-1].exp_rgb));
                chk($sformatf("vec%0d_hs", i - 1), 32'(hsync_out), 32'(vecs[i-1].hs));
                chk($sformatf("vec%0d_vs", i - 1), 32'(vsync_out), 32'(vecs[i-1].vs));
            end
        end
        chk("ft_none_yet", 32'(ft_cnt), 32'd0);

        // Compressed frame: every line, a few columns each.
        ft_before = ft_cnt;
        for (int y = 0; y < 525; y++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk) drive((k == 0) ? 10'd0 : (k == 1) ? 10'd639 : 10'd799,
                                     10'(y), (y < 480 && k < 2), 1'b0, 1'b0);
                tick();
            end
        end
        chk("frame_one_tick", 32'(ft_cnt - ft_before), 32'd1);
        chk("frame_box_x", 32'(dut.u_motion.box_x), 32'd2);
        chk("frame_box_y", 32'(dut.u_motion.box_y), 32'd2);
        check_pixel("px_1_1_bg",   10'd1,  10'd1,  12'h00F);
        check_pixel("px_2_2_box",  10'd2,  10'd2,  12'hF00);
        check_pixel("px_33_33_box", 10'd33, 10'd33, 12'hF00);
        check_pixel("px_34_2_bg",  10'd34, 10'd2,  12'h00F);

        // frame_tick: one clk wide, one clk after the qualifying p_tick.
        @(negedge clk) begin drive(10'd0, 10'd480, 1'b0, 1'b0, 1'b0); p_tick = 1'b1; end
        @(negedge clk) p_tick = 1'b0;
        chk("ft_high",    32'(frame_tick), 32'd1);
        chk("ft_moved_y", 32'(dut.u_motion.box_y), 32'd4);
        @(negedge clk);
        chk("ft_low",     32'(frame_tick), 32'd0);
        @(negedge clk);

        // Events 3..223 -> y=446, then bottom bounce.
        for (int n = 3; n <= 223; n++) frame_event();
        chk("y_446",  32'(dut.u_motion.box_y), 32'd446);
        frame_event();
        chk("y_448",  32'(dut.u_motion.box_y), 32'd448);
        frame_event();
        chk("y_446b", 32'(dut.u_motion.box_y), 32'd446);
        chk("x_450",  32'(dut.u_motion.box_x), 32'd450);

        // Events 226..303 -> x=606, then right bounce.
        for (int n = 226; n <= 303; n++) frame_event();
        chk("x_606",  32'(dut.u_motion.box_x), 32'd606);
        frame_event();
        chk("x_608",  32'(dut.u_motion.box_x), 32'd608);
        frame_event();
        chk("x_606b", 32'(dut.u_motion.box_x), 32'd606);
        chk("y_286",  32'(dut.u_motion.box_y), 32'd286);

`ifdef VGA_BOX_PAUSE_EN
        pause = 1'b1;
        ft_before = ft_cnt;
        for (int n = 0; n < 3; n++) frame_event();
        pause = 1'b0;
        chk("pause_ticks", 32'(ft_cnt - ft_before), 32'd3);
        chk("pause_x", 32'(dut.u_motion.box_x), 32'd606);
        chk("pause_y", 32'(dut.u_motion.box_y), 32'd286);
`endif

        // Mid-line reset with the box pixel and syncs in flight.
        @(negedge clk) drive(10'd610, 10'd290, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("pre_rst_rgb", 32'(rgb), 32'hF00);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst_mid_rgb", 32'(rgb), 32'h0);
        chk("rst_mid_hs",  32'(hsync_out), 32'h0);
        chk("rst_mid_x",   32'(dut.u_motion.box_x), 32'd0);
        chk("rst_mid_y",   32'(dut.u_motion.box_y), 32'd0);
        @(negedge clk) drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rst_no_stale", 32'(rgb), 32'h0);
        tick();
        chk("rst_resume", 32'(rgb), 32'hF00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vga_box_render.md
# vga_box_render

Pixel-generation stage directly downstream of the 640x480 VGA sync generator. It consumes the generator's pixel coordinates, `video_on`, pixel-enable tick and registered syncs. It draws a solid square that bounces off the screen edges, updating its position once per frame during vertical blanking. Its outputs are 12-bit RGB plus hsync/vsync, delayed to stay pixel-aligned with the colour data, and they drive the VGA DAC pins directly.

## Interface
- `H_RES`, 640: active pixels per line.
- `V_RES`, 480: active lines per frame.
- `BOX_SIZE`, 32: square edge length in pixels.
- `STEP`, 2: pixels moved per frame on each axis.
- `BOX_COLOR`, 12'hF00: square colour (4:4:4 RGB).
- `BG_COLOR`, 12'h00F: background colour in the active area.

Ports:
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: reset, synchronous, active-high.
- `p_tick` in 1: pixel enable, one `clk` every 4.
- `video_on` in 1: active-area flag from the sync generator.
- `hsync_in` in 1: horizontal sync from the sync generator.
- `vsync_in` in 1: vertical sync from the sync generator.
- `pixel_x` in 10: current column, 0..799.
- `pixel_y` in 10: current line, 0..524.
- `pause` in 1: freezes motion. This port exists only with `VGA_BOX_PAUSE_EN`.
- `hsync_out` out 1: `hsync_in` delayed by 2 pixel ticks.
- `vsync_out` out 1: `vsync_in` delayed by 2 pixel ticks.
- `rgb` out 12: pixel colour.
- `frame_tick` out 1: one-`clk` pulse when the position updates.

## Operation
- Frame event:
  - Detected when `p_tick && pixel_x==0 && pixel_y==V_RES`, i.e. the first blank line.
  - `frame_tick` is registered and asserts on the next `clk`.
  - Position and direction update in that same cycle.
  - The square therefore never moves while active lines are being drawn (no tearing).
- Motion state:
  - `box_x`, `box_y` are 10 bits each; `dir_x` (1 = right) and `dir_y` (1 = down) are 1 bit each.
  - All sums and comparisons are evaluated in 11 bits, so edge arithmetic cannot overflow.
- Horizontal update on a frame event:
  - Moving right: if `box_x+STEP >= H_RES-BOX_SIZE`, set `box_x = H_RES-BOX_SIZE` and `dir_x = 0`; otherwise `box_x += STEP`.
  - Moving left: if `box_x <= STEP`, set `box_x = 0` and `dir_x = 1`; otherwise `box_x -= STEP`.
- Vertical update: identical to horizontal, using `V_RES` and `dir_y`.
- Render pipeline, both stages advancing only on `p_tick`:
  - S1 registers `hit`, `video_on`, `hsync_in` and `vsync_in`.
  - `hit = pixel_x in [box_x, box_x+BOX_SIZE) && pixel_y in [box_y, box_y+BOX_SIZE)`.
  - S2 registers `rgb`: `!video_on_s1` gives 0; else `hit_s1` gives `BOX_COLOR`; else `BG_COLOR`. S2 also registers the syncs.
- Reset values:
  - `box_x = box_y = 0`, `dir_x = dir_y = 1`.
  - `rgb = 0`, `hsync_out = vsync_out = 0`, `frame_tick = 0`.
  - All pipeline registers clear.
- Reset mid-frame: all state returns to the reset values on the next `clk`. Drawing resumes from the upstream counters with no stale pixels.

## Timing
- Pixel latency: 2 `p_tick` periods (8 `clk`) from coordinate input to `rgb`.
- The syncs see exactly the same latency, so the colour/sync relationship is preserved.
- Between `p_tick`s all pipeline outputs hold.
- `frame_tick`: exactly one pulse per 800x525 frame, 1 `clk` wide, asserted 1 `clk` after the qualifying `p_tick`.
- When a frame event coincides with a blank pixel, rendering is unaffected: S1 uses the pre-update position for that pixel, and that pixel is blank anyway.

## Configuration
- `VGA_BOX_PAUSE_EN` defined: the `pause` port exists. While `pause=1` at a frame event, position and direction hold, and `frame_tick` still pulses.
- Not defined: the port is absent and motion is unconditional.

## Structure
- Shared package `vga_anim_pkg`:
  - Constants: `H_RES`/`V_RES` defaults and the 800/525 totals.
  - Type: `rgb_t` (12-bit).
  - Colour constants: `COLOR_BLACK`, `COLOR_RED`, `COLOR_BLUE`.
- One sub-module, `box_motion`, holds the position/direction registers and the edge logic.
  - Inputs: `clk`, `rst`, `step_en`.
  - Outputs: `box_x`, `box_y`.
  - `vga_box_render` owns frame detection and the render pipeline.

## Test plan
- Reset: hold `rst` 3 cycles, then drive `p_tick`. Expect `rgb=0`, `hsync_out=vsync_out=0`, box at (0,0).
- Pixel (0,0) with `video_on=1` after reset: `rgb=12'hF00` 2 `p_tick`s later. Pixel (32,0): `12'h00F`. Pixel (700,0) with `video_on=0`: 0.
- One full frame: exactly one `frame_tick`; box moves to (2,2); pixel (1,1) now renders `12'h00F`.
- Right edge: from `box_x=606` moving right, next event gives `box_x=608`, `dir_x=0`; the following event gives 606. Bottom edge: `box_y=446` down gives 448 then 446.
- Sync alignment: toggle `hsync_in` on a known `p_tick`. `hsync_out` follows exactly 2 `p_tick`s later; the same holds for `vsync`.
- With `VGA_BOX_PAUSE_EN`: `pause=1` across 3 frames gives 3 `frame_tick` pulses with the position unchanged. Also assert `rst` mid-line: state is cleared on the next `clk`.
